// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Optional divider datapath is compiled in when MULDIV_DIVIDE_EN is defined.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        hiWrite,
  input  logic        loWrite,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        opUnsupported,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t      state, next_state;
  logic        accept;
  logic [31:0] a_q, b_q;
  logic        unsigned_q;
  logic        neg_q;
  logic [31:0] m_reg, acc, mq;
  logic [4:0]  cnt;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum;

  assign mag_a = (!unsigned_q && a_q[31]) ? -a_q : a_q;
  assign mag_b = (!unsigned_q && b_q[31]) ? -b_q : b_q;
  assign sum   = {1'b0, acc} + {1'b0, (mq[0] ? m_reg : 32'd0)};

`ifdef MULDIV_DIVIDE_EN
  logic        div_q, neg_r, div_zero;
  logic [32:0] shifted, diff;

  assign shifted       = {acc, mq[31]};
  assign diff          = shifted - {1'b0, m_reg};
  assign accept        = (state == IDLE) && start;
  assign opUnsupported = 1'b0;
`else
  logic reject;

  assign reject = (state == IDLE) && start && op[1];
  assign accept = (state == IDLE) && start && !op[1];

  always_ff @(posedge clk) begin
    if (!rst) opUnsupported <= 1'b0;
    else      opUnsupported <= reject;
  end
`endif

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = PREP;
      PREP:    next_state = RUN;
      RUN:     if (cnt == 5'd31) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == FIX);
      if (state == IDLE && !start) begin
        if (hiWrite) hi <= writeData;
        if (loWrite) lo <= writeData;
      end else if (state == FIX) begin
`ifdef MULDIV_DIVIDE_EN
        if (div_q) begin
          if (div_zero) begin
            hi <= a_q;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= neg_r ? -acc : acc;
            lo <= neg_q ? -mq : mq;
          end
        end else
`endif
          {hi, lo} <= neg_q ? -{acc, mq} : {acc, mq};
      end
    end
  end

  // NOTE: datapath registers carry no reset; the FSM never consumes them before loading them.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_q        <= operandA;
        b_q        <= operandB;
        unsigned_q <= op[0];
`ifdef MULDIV_DIVIDE_EN
        div_q      <= op[1];
`endif
      end
      PREP: begin
        acc   <= 32'd0;
        cnt   <= 5'd0;
        neg_q <= !unsigned_q && (a_q[31] ^ b_q[31]);
`ifdef MULDIV_DIVIDE_EN
        neg_r    <= !unsigned_q && a_q[31];
        div_zero <= (b_q == 32'd0);
        if (div_q) begin
          m_reg <= mag_b;
          mq    <= mag_a;
        end else
`endif
        begin
          m_reg <= mag_a;
          mq    <= mag_b;
        end
      end
      RUN: begin
        cnt <= cnt + 5'd1;
`ifdef MULDIV_DIVIDE_EN
        // Restoring step: keep the trial subtraction only when it does not go negative.
        if (div_q) begin
          acc <= diff[32] ? shifted[31:0] : diff[31:0];
          mq  <= {mq[30:0], ~diff[32]};
        end else
`endif
        begin
          acc <= sum[32:1];
          mq  <= {sum[0], mq[31:1]};
        end
      end
      default: ;
    endcase
  end

endmodule
